memory_slave: RTL and testbench
===============================

Name: memory_slave

Overview:
- Responder end of the memory-model bus. The testbench, or a master, drives req/wr/addr/wdata. This block stores data and returns rdata plus a one-cycle slv_rsp pulse.
- Holds a MEM_SIZE-deep register array. The array is reachable by hierarchical path for RAL backdoor peek/poke.
- Sits as the DUT behind the memory interface. It executes one transaction at a time.

Parameters:
- ADDR_WIDTH, 8, address bus width in bits.
- DATA_WIDTH, 32, data bus width in bits.
- MEM_SIZE, 16, number of words. Valid addresses are 0..MEM_SIZE-1.
- RD_LATENCY, 2, cycles from the request-capture edge to the read-response edge. Legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request valid; sampled only while idle.
- wr  input  1  1 = write, 0 = read; sampled with req.
- addr  input  ADDR_WIDTH  word address; sampled with req.
- wdata  input  DATA_WIDTH  write data; sampled with req when wr=1.
- rdata  output  DATA_WIDTH  read data; valid while slv_rsp=1 for a read; holds its value otherwise.
- slv_rsp  output  1  one-cycle completion pulse for every accepted transaction.
- err  output  1  asserted together with slv_rsp when the captured addr >= MEM_SIZE.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - rdata=0, slv_rsp=0, err=0, busy=0.
  - All mem words = 0; wait counter = 0.
  - Any in-flight transaction is discarded and produces no slv_rsp.
  - First acceptance is possible at the first rising edge after reset deasserts.
- Storage: mem[0:MEM_SIZE-1], DATA_WIDTH bits each. Only the front door or backdoor modifies it.
- FSM states: IDLE, WR_COMMIT, RD_WAIT, RESP.
- IDLE:
  - At an edge with req=1, capture wr/addr/wdata into holding registers.
  - Compute oor = (addr >= MEM_SIZE), comparing at full ADDR_WIDTH without truncation.
  - wr=1 -> WR_COMMIT.
  - wr=0 -> RD_WAIT, with counter loaded to RD_LATENCY-1.
  - req=0 -> stay in IDLE.
- WR_COMMIT (one cycle):
  - At the next edge, if !oor, mem[addr_q] <= wdata_q; if oor, the write is dropped.
  - Go to RESP with slv_rsp<=1 and err<=oor.
- RD_WAIT:
  - At each edge, if counter!=0, decrement it.
  - If counter==0: rdata <= oor ? 0 : mem[addr_q]; slv_rsp<=1; err<=oor; go to RESP.
- RESP:
  - slv_rsp and err are high for exactly this one cycle.
  - At the next edge: slv_rsp<=0, err<=0, go to IDLE.
  - req is not accepted in this cycle.
- Latency, taking capture edge = T:
  - Write response: slv_rsp high between edges T+1 and T+2.
  - Read response: slv_rsp high between edges T+RD_LATENCY and T+RD_LATENCY+1.
  - Next acceptance is no earlier than edge T+3 (write) or T+RD_LATENCY+2 (read).
- req while busy: ignored, not queued. The master must wait for slv_rsp and then for busy=0.
- Input changes while busy have no effect; captured values are used.
- Read-after-write to the same address returns the new data: the write commits before the read can be captured.
- rdata is not updated by writes. It keeps the last read value, or 0 after reset.
- Backdoor writes to mem take effect for any read whose fetch edge comes after them.
- Registered outputs only; no combinational path from inputs to outputs.

Test Plan:
- Reset, then read addr 5 with RD_LATENCY=2 -> slv_rsp pulses 2 edges after capture, rdata=0, err=0.
- Write addr 3 = 32'hA5A5_0003, then read addr 3 -> write slv_rsp 1 cycle after capture; read returns 32'hA5A5_0003, err=0.
- Write addr 20 (MEM_SIZE=16) = 32'h1234 -> slv_rsp=1 with err=1, mem unchanged. Then read addr 20 -> rdata=0, err=1.
- Hold req=1 continuously with alternating writes to addr 0..15 -> one transaction accepted per IDLE visit only; busy high and reqs ignored in between; each captured value is read back correctly.
- Assert reset during RD_WAIT of a read to addr 7 (previously 32'hDEAD_0007) -> outputs 0 immediately, no slv_rsp, and a subsequent read of addr 7 returns 0.
- Backdoor-poke mem[9]=32'hCAFE_0009, then front-door read addr 9 -> rdata=32'hCAFE_0009. Front-door write addr 9 = 32'h0, then backdoor peek -> 32'h0.

Source files
------------

// File: rtl/memory_slave.sv
// memory_slave: responder end of the memory-model bus.
//
// Accepts one transaction at a time while idle, stores write data in a
// MEM_SIZE-deep register array and answers every accepted transaction with
// a one-cycle slv_rsp pulse (plus err for out-of-range addresses). The
// array is named 'mem' so it can be reached hierarchically for backdoor
// peek/poke.
//
// Ports:
//   clk      - single clock, rising-edge
//   reset    - asynchronous active-high reset
//   req      - request valid, sampled only while idle
//   wr       - 1 = write, 0 = read, sampled with req
//   addr     - word address, sampled with req
//   wdata    - write data, sampled with req
//   rdata    - read data, valid with slv_rsp on a read, held otherwise
//   slv_rsp  - one-cycle completion pulse
//   err      - out-of-range flag, high together with slv_rsp
//   busy     - high whenever the FSM is not idle
module memory_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  slv_rsp,
  output logic                  err,
  output logic                  busy
);

  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_COMMIT = 2'd1,
    RD_WAIT   = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic                  capture_s;
  logic                  commit_s;
  logic                  fetch_s;
  logic                  rsp_set_s;
  logic                  oor_s;
  logic [IDX_W-1:0]      idx_s;

  // Range check on the captured address at full width (no truncation), so
  // addresses that alias into the array when sliced are still flagged.
  assign oor_s = (64'(addr_r) >= 64'(MEM_SIZE));
  // Only used when oor_s is low, so the slice always names a real word.
  assign idx_s = addr_r[IDX_W-1:0];

  // Next-state and per-cycle action decode.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    commit_s    = 1'b0;
    fetch_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) begin
          capture_s   = 1'b1;
          state_nxt_s = wr ? WR_COMMIT : RD_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR_COMMIT: begin
        commit_s    = 1'b1;
        state_nxt_s = RESP;
      end
      RD_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          fetch_s     = 1'b1;
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = RD_WAIT;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    rsp_set_s = commit_s | fetch_s;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Transaction holding registers and read-latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
    end else if (capture_s) begin
      addr_r  <= addr;
      wdata_r <= wdata;
      cnt_r   <= CNT_LOAD;
    end else if ((state_r == RD_WAIT) && (cnt_r != CNT_ZERO)) begin
      cnt_r   <= cnt_r - CNT_ONE;
    end
  end

  // Storage array; out-of-range writes are silently dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (commit_s && !oor_s) begin
      mem[idx_s] <= wdata_r;
    end
  end

  // Registered outputs. rdata only changes on a read fetch; busy mirrors
  // the state the FSM is entering so it is exact without a combinational path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata   <= {DATA_WIDTH{1'b0}};
      slv_rsp <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (fetch_s) begin
        rdata <= oor_s ? {DATA_WIDTH{1'b0}} : mem[idx_s];
      end
      slv_rsp <= rsp_set_s;
      err     <= rsp_set_s & oor_s;
      busy    <= (state_nxt_s != IDLE);
    end
  end

endmodule

// File: tb/tb_memory_slave.sv
// tb_memory_slave: directed bench for memory_slave with a transaction-level
// reference model checked against the DUT on every falling edge.
module tb_memory_slave;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  addr = 8'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        slv_rsp;
  logic        err;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic chk_on = 1'b0;

  memory_slave #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .MEM_SIZE(16),
    .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .wr(wr),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .slv_rsp(slv_rsp),
    .err(err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction timing from edge counts, storage as an array.
  int          cyc = 0;
  int          rsp_edge = -10;
  int          next_acc = 0;
  logic        m_wr = 1'b0;
  logic        m_oor = 1'b0;
  logic [7:0]  m_addr = 8'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] model_mem [16];
  logic [31:0] e_rdata = 32'd0;
  logic        e_rsp = 1'b0;
  logic        e_err = 1'b0;
  logic        e_busy = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) model_mem[i] = 32'd0;
      e_rdata  = 32'd0;
      e_rsp    = 1'b0;
      e_err    = 1'b0;
      e_busy   = 1'b0;
      rsp_edge = -10;
      next_acc = cyc + 1;
    end else begin
      cyc   = cyc + 1;
      e_rsp = 1'b0;
      e_err = 1'b0;
      if (cyc == rsp_edge) begin
        if (m_wr) begin
          if (!m_oor) model_mem[m_addr[3:0]] = m_wdata;
        end else begin
          e_rdata = m_oor ? 32'd0 : model_mem[m_addr[3:0]];
        end
        e_rsp = 1'b1;
        e_err = m_oor;
      end
      if (req && cyc >= next_acc) begin
        m_wr     = wr;
        m_addr   = addr;
        m_wdata  = wdata;
        m_oor    = (addr >= 8'd16);
        rsp_edge = wr ? cyc + 1 : cyc + RD_LAT;
        next_acc = rsp_edge + 2;
      end
      e_busy = (cyc < next_acc - 1);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_slv_rsp", 32'(slv_rsp), 32'(e_rsp));
      chk("cyc_err", 32'(err), 32'(e_err));
      chk("cyc_busy", 32'(busy), 32'(e_busy));
      chk("cyc_rdata", rdata, e_rdata);
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  // One front-door transaction with latency, err and (optionally) rdata checks.
  task automatic txn(input string name, input logic w, input logic [7:0] a,
                     input logic [31:0] d, input int exp_lat,
                     input logic exp_e, input logic chk_rd, input logic [31:0] exp_rd);
    int k = 0;
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; wr = 1'b0; addr = 8'd0; wdata = 32'd0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (slv_rsp !== 1'b1 && k < 40);
    chk({name, "_latency"}, 32'(k), 32'(exp_lat));
    chk({name, "_err"}, 32'(err), 32'(exp_e));
    if (chk_rd) chk({name, "_rdata"}, rdata, exp_rd);
    wait_idle(name);
  endtask

  logic [31:0] exp_v;

  initial begin
    repeat (3) @(posedge clk);
    chk_on = 1'b1;
    #1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp", 32'(slv_rsp), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Read after reset
    txn("rd5", 1'b0, 8'd5, 32'd0, 2, 1'b0, 1'b1, 32'd0);

    // Write then read back
    txn("wr3", 1'b1, 8'd3, 32'hA5A5_0003, 1, 1'b0, 1'b0, 32'd0);
    txn("rd3", 1'b0, 8'd3, 32'd0, 2, 1'b0, 1'b1, 32'hA5A5_0003);

    // Out-of-range write and read
    txn("wr20", 1'b1, 8'd20, 32'h0000_1234, 1, 1'b1, 1'b0, 32'd0);
    chk("wr20_no_alias", dut.mem[4], 32'd0);
    txn("rd20", 1'b0, 8'd20, 32'd0, 2, 1'b1, 1'b1, 32'd0);

    // Continuous req: only one capture per idle visit
    @(negedge clk);
    req = 1'b1; wr = 1'b1;
    for (int i = 0; i < 60; i++) begin
      addr = 8'(i % 16);
      wdata = 32'h5000_0000 + 32'(i);
      @(negedge clk);
    end
    req = 1'b0; wr = 1'b0;
    wait_idle("hold");
    chk("model_pin_a0", model_mem[0], 32'h5000_0030);
    chk("model_pin_a3", model_mem[3], 32'h5000_0033);
    for (int a = 0; a < 16; a++) begin
      exp_v = model_mem[a];
      txn("hold_rb", 1'b0, 8'(a), 32'd0, 2, 1'b0, 1'b1, exp_v);
    end

    // Reset during RD_WAIT
    txn("wr7", 1'b1, 8'd7, 32'hDEAD_0007, 1, 1'b0, 1'b0, 32'd0);
    txn("rd7", 1'b0, 8'd7, 32'd0, 2, 1'b0, 1'b1, 32'hDEAD_0007);
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 8'd7;
    @(posedge clk);
    #1;
    req = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mid_rdata", rdata, 32'd0);
    chk("rst_mid_rsp", 32'(slv_rsp), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_rsp", 32'(slv_rsp), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    txn("rd7_after_rst", 1'b0, 8'd7, 32'd0, 2, 1'b0, 1'b1, 32'd0);

    // Backdoor poke then front-door read; front-door write then backdoor peek
    @(negedge clk);
    dut.mem[9] <= 32'hCAFE_0009;
    model_mem[9] = 32'hCAFE_0009;
    txn("rd9_poke", 1'b0, 8'd9, 32'd0, 2, 1'b0, 1'b1, 32'hCAFE_0009);
    txn("wr9", 1'b1, 8'd9, 32'h0, 1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("peek9", dut.mem[9], 32'h0);

    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
